// File: rtl/if_pc_gen_pkg.sv
// Shared constants for the fetch-address generator: instruction width, reset PC,
// fetch granule, and the alignment helper used when IF_PC_ALIGN_CHK_EN is defined.
package if_pc_gen_pkg;
  localparam int          INST_W         = 32;
  localparam logic [63:0] PC_START_DEF   = 64'h8000_0000;
  localparam int          INST_BYTES_DEF = 4;

  function automatic logic is_misaligned(input logic [63:0] pc, input int ib);
    return (pc & 64'(ib - 1)) != 64'd0;
  endfunction
endpackage

// File: rtl/if_pc_queue.sv
// In-order outstanding-fetch queue: allocate at tail, fill in request order
// (skipping entries born filled), pop at head.
module if_pc_queue
  import if_pc_gen_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic              alloc_epoch_i,
  input  logic              alloc_filled_i,
  input  logic              alloc_exc_i,
  input  logic              fill_i,
  input  logic [INST_W-1:0] fill_inst_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic              head_epoch_o,
  output logic              head_filled_o,
  output logic              head_exc_o,
  output logic [INST_W-1:0] head_inst_o
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              epoch;
    logic [INST_W-1:0] inst;
    logic              filled;
    logic              exc;
  } entry_t;

  entry_t          q_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q, fill_q;
  logic [PW:0]     cnt_q;
  logic [PW-1:0]   fill_idx, idx, off;
  logic            fill_ok;

  // Response target: first occupied, unfilled slot at or after the fill pointer.
  always_comb begin
    fill_idx = fill_q;
    fill_ok  = 1'b0;
    idx      = '0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = fill_q + PW'(i);
      off = idx - head_q;
      if (!fill_ok && ({1'b0, off} < cnt_q) && !q_q[idx].filled) begin
        fill_idx = idx;
        fill_ok  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
    end else begin
      if (alloc_i) begin
        q_q[tail_q] <= '{addr: alloc_addr_i, epoch: alloc_epoch_i, inst: '0,
                         filled: alloc_filled_i, exc: alloc_exc_i};
        tail_q <= tail_q + 1'b1;
      end
      if (fill_i && fill_ok) begin
        q_q[fill_idx].inst   <= fill_inst_i;
        q_q[fill_idx].filled <= 1'b1;
      end
      fill_q <= (fill_i && fill_ok) ? fill_idx + 1'b1 : fill_idx;
      if (pop_i) head_q <= head_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(alloc_i) - (PW+1)'(pop_i);
    end
  end

  assign full_o        = cnt_q == (PW+1)'(DEPTH);
  assign empty_o       = cnt_q == '0;
  assign head_addr_o   = q_q[head_q].addr;
  assign head_epoch_o  = q_q[head_q].epoch;
  assign head_filled_o = q_q[head_q].filled;
  assign head_exc_o    = q_q[head_q].exc;
  assign head_inst_o   = q_q[head_q].inst;
endmodule

// File: rtl/if_pc_gen.sv
// Fetch PC / epoch / halt control in front of the outstanding-fetch queue.
// Optional misaligned-fetch trap: define IF_PC_ALIGN_CHK_EN.
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter int              ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] PC_START = ADDR_W'(PC_START_DEF),
  parameter int              DEPTH      = 4,
  parameter int              INST_BYTES = INST_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redir_valid_i,
  input  logic [ADDR_W-1:0] redir_addr_i,
  input  logic              pred_valid_i,
  input  logic [ADDR_W-1:0] pred_addr_i,
  input  logic              stall_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  input  logic              rsp_valid_i,
  input  logic [INST_W-1:0] rsp_inst_i,
  output logic              out_valid_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [INST_W-1:0] out_inst_o,
  output logic              out_exc_o,
  input  logic              out_ready_i
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              epoch_q, epoch_d, halt_q, halt_d;
  logic              full, empty, head_epoch, head_filled, head_exc;
  logic [ADDR_W-1:0] head_addr;
  logic [INST_W-1:0] head_inst;
  logic              misalign, exc_alloc, req_fire, head_live, pop;

`ifdef IF_PC_ALIGN_CHK_EN
  assign misalign  = is_misaligned(64'(pc_q), INST_BYTES);
  assign exc_alloc = rst_n & misalign & ~stall_i & ~redir_valid_i & ~full & ~halt_q;
`else
  assign misalign  = 1'b0;
  assign exc_alloc = 1'b0;
`endif

  // Gated by rst_n so the handshake stays quiet while reset is held.
  assign req_valid_o = rst_n & ~stall_i & ~redir_valid_i & ~full & ~halt_q & ~misalign;
  assign req_addr_o  = pc_q;
  assign req_fire    = req_valid_o & req_ready_i;

  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    halt_d  = halt_q;
    if (redir_valid_i) begin
      pc_d    = redir_addr_i;
      epoch_d = ~epoch_q;
      halt_d  = 1'b0;
    end else if (req_fire) begin
      pc_d = pred_valid_i ? pred_addr_i : pc_q + ADDR_W'(INST_BYTES);
    end else if (exc_alloc) begin
      halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= PC_START;
      epoch_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      halt_q  <= halt_d;
    end
  end

  // Stale heads (older epoch) drain one per cycle without reaching decode.
  assign head_live   = ~empty & head_filled;
  assign out_valid_o = head_live & (head_epoch == epoch_q);
  assign pop         = head_live & ((head_epoch != epoch_q) | out_ready_i);
  assign out_addr_o  = out_valid_o ? head_addr : '0;
  assign out_inst_o  = out_valid_o ? head_inst : '0;
  assign out_exc_o   = out_valid_o & head_exc;

  if_pc_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_queue (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_i       (req_fire | exc_alloc),
    .alloc_addr_i  (pc_q),
    .alloc_epoch_i (epoch_q),
    .alloc_filled_i(exc_alloc),
    .alloc_exc_i   (exc_alloc),
    .fill_i        (rsp_valid_i),
    .fill_inst_i   (rsp_inst_i),
    .pop_i         (pop),
    .full_o        (full),
    .empty_o       (empty),
    .head_addr_o   (head_addr),
    .head_epoch_o  (head_epoch),
    .head_filled_o (head_filled),
    .head_exc_o    (head_exc),
    .head_inst_o   (head_inst)
  );
endmodule

// File: tb/tb_if_pc_gen.sv
// Randomised + directed bench for if_pc_gen with a queue-based reference model
// and an in-order imem model with configurable latency.
module tb_if_pc_gen;
  localparam int          DEPTH = 4;
  localparam int          IB    = 4;
  localparam logic [63:0] PCS   = 64'h8000_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        redir_valid_i = 0, pred_valid_i = 0, stall_i = 0, req_ready_i = 0;
  logic        rsp_valid_i = 0, out_ready_i = 0;
  logic [63:0] redir_addr_i = '0, pred_addr_i = '0;
  logic [31:0] rsp_inst_i = '0;
  logic        req_valid_o, out_valid_o, out_exc_o;
  logic [63:0] req_addr_o, out_addr_o;
  logic [31:0] out_inst_o;

  if_pc_gen #(.ADDR_W(64), .PC_START(PCS), .DEPTH(DEPTH), .INST_BYTES(IB)) dut (
    .clk(clk), .rst_n(rst_n),
    .redir_valid_i(redir_valid_i), .redir_addr_i(redir_addr_i),
    .pred_valid_i(pred_valid_i), .pred_addr_i(pred_addr_i),
    .stall_i(stall_i),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_inst_i(rsp_inst_i),
    .out_valid_o(out_valid_o), .out_addr_o(out_addr_o), .out_inst_o(out_inst_o),
    .out_exc_o(out_exc_o), .out_ready_i(out_ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef struct { logic [63:0] addr; bit ep; bit filled; logic [31:0] inst; bit exc; } ment_t;
  typedef struct { logic [63:0] addr; int due; } imem_t;
  ment_t mq[$];
  imem_t iq[$];
  logic [63:0] m_pc;
  bit          m_ep, m_halt;
  int          cyc, last_due;

  bit          s_redir, s_pred, s_stall, s_rdy, s_ordy, hold;
  logic [63:0] s_redir_addr, s_pred_addr;
  int          lat_lo = 1, lat_hi = 1;

  bit          sv_rv, sv_ov, sv_exc;
  logic [63:0] sv_ra, sv_oa;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit mis(input logic [63:0] a);
`ifdef IF_PC_ALIGN_CHK_EN
    return (a & 64'(IB - 1)) != 64'd0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs();
    #1;
    chk("rst_req_valid", 64'(req_valid_o), 64'd0);
    chk("rst_req_addr",  req_addr_o, PCS);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_out_addr",  out_addr_o, 64'd0);
    chk("rst_out_inst",  64'(out_inst_o), 64'd0);
    chk("rst_out_exc",   64'(out_exc_o), 64'd0);
  endtask

  // Called just after a posedge; leaves just after the next posedge.
  task automatic do_reset();
    {redir_valid_i, pred_valid_i, stall_i, req_ready_i, rsp_valid_i, out_ready_i} = '0;
    rst_n = 1'b0;
    chk_reset_outputs();
    mq.delete(); iq.delete();
    m_pc = PCS; m_ep = 0; m_halt = 0; last_due = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic step();
    bit rsp, e_rv, e_ex, e_ov, stale, found;
    logic [31:0] r_inst;
    logic [63:0] e_oa;
    logic [31:0] e_oi;
    bit e_exc;
    rsp    = !hold && iq.size() > 0 && iq[0].due <= cyc;
    r_inst = rsp ? inst_of(iq[0].addr) : 32'($urandom);
    redir_valid_i = s_redir; redir_addr_i = s_redir_addr;
    pred_valid_i  = s_pred;  pred_addr_i  = s_pred_addr;
    stall_i = s_stall; req_ready_i = s_rdy; out_ready_i = s_ordy;
    rsp_valid_i = rsp; rsp_inst_i = r_inst;

    e_rv  = !s_stall && !s_redir && mq.size() < DEPTH && !m_halt && !mis(m_pc);
    e_ex  = !s_stall && !s_redir && mq.size() < DEPTH && !m_halt && mis(m_pc);
    e_ov  = mq.size() > 0 && mq[0].filled && mq[0].ep == m_ep;
    stale = mq.size() > 0 && mq[0].filled && mq[0].ep != m_ep;
    e_oa  = e_ov ? mq[0].addr : 64'd0;
    e_oi  = e_ov ? mq[0].inst : 32'd0;
    e_exc = e_ov ? mq[0].exc : 1'b0;

    @(negedge clk);
    chk("req_valid", 64'(req_valid_o), 64'(e_rv));
    chk("req_addr",  req_addr_o, m_pc);
    chk("out_valid", 64'(out_valid_o), 64'(e_ov));
    chk("out_exc",   64'(out_exc_o), 64'(e_exc));
    if (e_ov) begin
      chk("out_addr", out_addr_o, e_oa);
      chk("out_inst", 64'(out_inst_o), 64'(e_oi));
    end
    sv_rv = req_valid_o; sv_ra = req_addr_o; sv_ov = out_valid_o;
    sv_oa = out_addr_o;  sv_exc = out_exc_o;

    @(posedge clk);
    if (rsp) begin
      found = 0;
      foreach (mq[i]) if (!found && !mq[i].filled) begin
        mq[i].filled = 1; mq[i].inst = r_inst; found = 1;
      end
      chk("rsp_has_unfilled_entry", 64'(found), 64'd1);
      void'(iq.pop_front());
    end
    if (stale || (e_ov && s_ordy)) void'(mq.pop_front());
    if (e_rv && s_rdy) begin
      int due;
      mq.push_back('{addr: m_pc, ep: m_ep, filled: 0, inst: 32'd0, exc: 0});
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due < last_due) due = last_due;
      last_due = due;
      iq.push_back('{addr: m_pc, due: due});
      m_pc = s_pred ? s_pred_addr : m_pc + 64'(IB);
    end else if (e_ex) begin
      mq.push_back('{addr: m_pc, ep: m_ep, filled: 1, inst: 32'd0, exc: 1});
      m_halt = 1;
    end
    if (s_redir) begin m_pc = s_redir_addr; m_ep = !m_ep; m_halt = 0; end
    cyc++;
    #1;
  endtask

  task automatic quiet();
    s_redir = 0; s_pred = 0; s_stall = 0; s_rdy = 1; s_ordy = 1; hold = 0;
    s_redir_addr = '0; s_pred_addr = '0;
  endtask

  initial begin
    int n, bad, ndec;
    logic [63:0] got, first_dec, last_dec;
    logic [63:0] dq[$];
    cyc = 0; last_due = 0;
    m_pc = PCS; m_ep = 0; m_halt = 0;
    quiet();
    #12;
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Sequential fetch, latency 1: addresses and decode order
    for (int i = 0; i < 8; i++) begin
      step();
      if (i < 3) chk("seq_req_addr", sv_ra, PCS + 64'(4 * i));
      if (sv_ov) dq.push_back(sv_oa);
    end
    chk("seq_dec_n",  64'(dq.size() >= 3), 64'd1);
    if (dq.size() >= 3) begin
      chk("seq_dec0", dq[0], 64'h8000_0000);
      chk("seq_dec1", dq[1], 64'h8000_0004);
      chk("seq_dec2", dq[2], 64'h8000_0008);
    end

    // Full queue blocks requests; one response + pop frees one slot
    do_reset(); quiet(); hold = 1; n = 0;
    repeat (6) begin step(); if (sv_rv) n++; end
    chk("full_req_count", 64'(n), 64'd4);
    chk("full_req_valid", 64'(sv_rv), 64'd0);
    hold = 0; step(); hold = 1; got = '0;
    for (int i = 0; i < 6; i++) begin step(); if (sv_rv) begin got = sv_ra; break; end end
    chk("full_next_addr", got, 64'h8000_0010);

    // Redirect with 3 outstanding: old responses are dropped
    do_reset(); quiet(); hold = 1;
    repeat (3) step();
    s_rdy = 0; s_redir = 1; s_redir_addr = 64'h8000_1000; step();
    s_redir = 0; hold = 0; bad = 0;
    repeat (5) begin step(); if (sv_ov) bad++; end
    chk("redir_stale_out", 64'(bad), 64'd0);
    s_rdy = 1; step();
    chk("redir_req_valid", 64'(sv_rv), 64'd1);
    chk("redir_req_addr",  sv_ra, 64'h8000_1000);
    s_rdy = 0; got = '0;
    for (int i = 0; i < 6; i++) begin step(); if (sv_ov) begin got = sv_oa; break; end end
    chk("redir_dec_addr", got, 64'h8000_1000);

    // Prediction, then prediction colliding with redirect
    do_reset(); quiet();
    step();
    s_pred = 1; s_pred_addr = 64'h8000_0100; step();
    chk("pred_at_pc", sv_ra, 64'h8000_0004);
    s_pred = 0; step();
    chk("pred_target", sv_ra, 64'h8000_0100);
    s_pred = 1; s_redir = 1; s_redir_addr = 64'h8000_2000; step();
    chk("redir_wins_no_req", 64'(sv_rv), 64'd0);
    s_pred = 0; s_redir = 0; step();
    chk("redir_wins_addr", sv_ra, 64'h8000_2000);

    // Stall holds PC; responses still fill, decode drains afterwards
    s_ordy = 0; repeat (2) step();
    s_stall = 1; n = 0;
    repeat (5) begin step(); if (sv_rv) n++; end
    chk("stall_no_req", 64'(n), 64'd0);
    chk("stall_pc_held", sv_ra, 64'h8000_200C);
    s_stall = 0; s_rdy = 0; s_ordy = 1; ndec = 0; first_dec = '0; last_dec = '0;
    repeat (8) begin
      step();
      if (sv_ov) begin if (ndec == 0) first_dec = sv_oa; last_dec = sv_oa; ndec++; end
    end
    chk("stall_drain_n", 64'(ndec), 64'd3);
    chk("stall_drain_first", first_dec, 64'h8000_2000);
    chk("stall_drain_last",  last_dec,  64'h8000_2008);

`ifdef IF_PC_ALIGN_CHK_EN
    // Misaligned redirect: one exception entry, no imem request, halt
    do_reset(); quiet();
    s_redir = 1; s_redir_addr = 64'h8000_0002; step();
    s_redir = 0; n = 0; got = '0; bad = 0;
    repeat (5) begin
      step(); if (sv_rv) n++;
      if (sv_ov) begin got = sv_oa; bad = int'(sv_exc); end
    end
    chk("exc_no_req", 64'(n), 64'd0);
    chk("exc_addr", got, 64'h8000_0002);
    chk("exc_flag", 64'(bad), 64'd1);
    s_redir = 1; s_redir_addr = 64'h8000_0008; step();
    s_redir = 0; step();
    chk("exc_resume_valid", 64'(sv_rv), 64'd1);
    chk("exc_resume_addr",  sv_ra, 64'h8000_0008);
`endif

    // Randomised traffic with variable imem latency and a mid-run reset
    do_reset(); lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) do_reset();
      s_redir = ($urandom_range(15) == 0);
      s_redir_addr = PCS + 64'($urandom_range(1023) * 4);
`ifdef IF_PC_ALIGN_CHK_EN
      if ($urandom_range(7) == 0) s_redir_addr = s_redir_addr + 64'($urandom_range(3, 1));
`endif
      s_pred = ($urandom_range(4) == 0);
      s_pred_addr = PCS + 64'($urandom_range(1023) * 4);
      s_stall = ($urandom_range(5) == 0);
      s_rdy = ($urandom_range(3) != 0);
      s_ordy = ($urandom_range(3) != 0);
      hold = 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
